// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
// The FIFO takes the slave side; the user logic driving push/pop takes the master side.
interface fifo_sync_param_if #(
   parameter int DATA_WIDTH = 6
);
   logic                  write;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  read;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   modport master (
      output write,
      output wr_data,
      output read,
      input  rd_data,
      input  rd_valid
   );

   modport slave (
      input  write,
      input  wr_data,
      input  read,
      output rd_data,
      output rd_valid
   );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// registered or first-word-fall-through read, and sticky overflow/underflow flags.
module fifo_sync_param #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset_L,
   fifo_sync_param_if.slave      bus,
   input  logic [ADDR_WIDTH:0]   umb_almost_full,
   input  logic [ADDR_WIDTH:0]   umb_almost_empty,
   input  logic                  clr_err,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   // A margin larger than the depth clamps the threshold to zero instead of wrapping.
   function automatic logic [ADDR_WIDTH:0] sat_sub(input logic [ADDR_WIDTH:0] a,
                                                   input logic [ADDR_WIDTH:0] b);
      return (b > a) ? '0 : (a - b);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   assign fifo_full    = (data_count == DEPTH_C);
   assign fifo_empty   = (data_count == '0);
   assign almost_full  = (data_count >= sat_sub(DEPTH_C, umb_almost_full));
   assign almost_empty = (data_count <= umb_almost_empty);

   // Acceptance looks only at the pre-edge count, so a same-cycle pop never frees room for a push.
   assign wr_acc = bus.write && !fifo_full;
   assign rd_acc = bus.read  && !fifo_empty;

   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   data_count <= data_count + CNT_ONE;
            2'b01:   data_count <= data_count - CNT_ONE;
            default: data_count <= data_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_L) begin
      if (reset_L) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (bus.write && fifo_full) overflow <= 1'b1;
         else if (clr_err)           overflow <= 1'b0;
         if (bus.read && fifo_empty) underflow <= 1'b1;
         else if (clr_err)           underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.wr_data;
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [DATA_WIDTH-1:0] rd_data_p1;
         logic                  vld_p1;

         // ---- stage p1: registered read port ----
         always_ff @(posedge clk or posedge reset_L) begin
            if (reset_L) begin
               rd_data_p1 <= '0;
               vld_p1     <= 1'b0;
            end else begin
               vld_p1 <= rd_acc;
               if (rd_acc) rd_data_p1 <= mem[rd_ptr];
            end
         end

         assign bus.rd_data  = rd_data_p1;
         assign bus.rd_valid = vld_p1;
      end else begin : g_fwft_read
         assign bus.rd_data  = mem[rd_ptr];
         assign bus.rd_valid = !fifo_empty;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a registered-read instance and an FWFT instance checked against a queue model.
module tb_fifo_sync_param;

   logic clk = 1'b0;
   logic reset_L = 1'b1;
   always #5 clk = ~clk;

   fifo_sync_param_if #(.DATA_WIDTH(6)) b0 ();
   fifo_sync_param_if #(.DATA_WIDTH(6)) b1 ();

   logic [2:0] umb_af0, umb_ae0, umb_af1, umb_ae1, dc0, dc1;
   logic clr0, clr1;
   logic full0, empty0, af0, ae0, ovf0, unf0;
   logic full1, empty1, af1, ae1, ovf1, unf1;

   fifo_sync_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .FWFT(0)) dut0 (
      .clk(clk), .reset_L(reset_L), .bus(b0.slave),
      .umb_almost_full(umb_af0), .umb_almost_empty(umb_ae0), .clr_err(clr0),
      .data_count(dc0), .fifo_full(full0), .fifo_empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0));

   fifo_sync_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2), .FWFT(1)) dut1 (
      .clk(clk), .reset_L(reset_L), .bus(b1.slave),
      .umb_almost_full(umb_af1), .umb_almost_empty(umb_ae1), .clr_err(clr1),
      .data_count(dc1), .fifo_full(full1), .fifo_empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1));

   int checks = 0;
   int errors = 0;

   logic [5:0] sb0[$];
   logic [5:0] sb1[$];
   int  m_cnt = 0;
   logic m_ovf = 1'b0;
   logic m_unf = 1'b0;

   // One clock on the registered-read instance; the model decides acceptance from the pre-edge count.
   task automatic cycle0(input logic w, input logic [5:0] d, input logic r, input logic clr);
      logic acc_w, acc_r;
      logic [5:0] exp;
      acc_w = w && (m_cnt != 4);
      acc_r = r && (m_cnt != 0);
      m_ovf = (w && m_cnt == 4) || (m_ovf && !clr);
      m_unf = (r && m_cnt == 0) || (m_unf && !clr);
      b0.write = w; b0.wr_data = d; b0.read = r; clr0 = clr;
      @(posedge clk); #1;
      b0.write = 1'b0; b0.read = 1'b0; clr0 = 1'b0;
      exp = '0;
      if (acc_r) exp = sb0.pop_front();
      if (acc_w) sb0.push_back(d);
      if (acc_w && !acc_r) m_cnt++;
      if (acc_r && !acc_w) m_cnt--;
      checks++;
      if (b0.rd_valid !== acc_r) begin
         errors++; $display("FAIL rd_valid0 got %b want %b", b0.rd_valid, acc_r);
      end
      if (acc_r) begin
         checks++;
         if (b0.rd_data !== exp) begin
            errors++; $display("FAIL rd_data0 got %h want %h", b0.rd_data, exp);
         end
      end
      checks++;
      if (dc0 !== 3'(m_cnt)) begin
         errors++; $display("FAIL count0 got %0d want %0d", dc0, m_cnt);
      end
      checks++;
      if (ovf0 !== m_ovf || unf0 !== m_unf) begin
         errors++; $display("FAIL err_flags0 got ovf=%b unf=%b want ovf=%b unf=%b", ovf0, unf0, m_ovf, m_unf);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (dc0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || ae0 !== 1'b1 || af0 !== 1'b0 ||
          b0.rd_valid !== 1'b0 || b0.rd_data !== 6'd0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
         errors++;
         $display("FAIL reset0 got cnt=%0d e=%b f=%b ae=%b af=%b v=%b d=%h o=%b u=%b want 0 1 0 1 0 0 00 0 0",
                  dc0, empty0, full0, ae0, af0, b0.rd_valid, b0.rd_data, ovf0, unf0);
      end
      checks++;
      if (dc1 !== 3'd0 || b1.rd_valid !== 1'b0 || empty1 !== 1'b1) begin
         errors++; $display("FAIL reset1 got cnt=%0d v=%b e=%b want 0 0 1", dc1, b1.rd_valid, empty1);
      end
   endtask

   task automatic test_fill_drain;
      logic [5:0] words [4] = '{6'h11, 6'h22, 6'h33, 6'h34};
      for (int i = 0; i < 4; i++) cycle0(1'b1, words[i], 1'b0, 1'b0);
      checks++;
      if (full0 !== 1'b1 || empty0 !== 1'b0) begin
         errors++; $display("FAIL full_after_fill got full=%b empty=%b want 1 0", full0, empty0);
      end
      for (int i = 0; i < 4; i++) cycle0(1'b0, 6'h00, 1'b1, 1'b0);
      checks++;
      if (empty0 !== 1'b1 || full0 !== 1'b0) begin
         errors++; $display("FAIL empty_after_drain got empty=%b full=%b want 1 0", empty0, full0);
      end
   endtask

   task automatic test_thresholds;
      umb_af0 = 3'd1; umb_ae0 = 3'd1;
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) cycle0(1'b1, 6'(c + 8), 1'b0, 1'b0);
         #1;
         checks++;
         if (ae0 !== (c <= 1) || af0 !== (c >= 3)) begin
            errors++; $display("FAIL thresh_c%0d got ae=%b af=%b want ae=%b af=%b", c, ae0, af0, c <= 1, c >= 3);
         end
      end
      for (int i = 0; i < 4; i++) cycle0(1'b0, 6'h00, 1'b1, 1'b0);
      umb_af0 = 3'd4; #1;
      checks++;
      if (af0 !== 1'b1) begin
         errors++; $display("FAIL thresh_af_margin4 got %b want 1", af0);
      end
      umb_af0 = 3'd5; umb_ae0 = 3'd0; #1;
      checks++;
      if (af0 !== 1'b1 || ae0 !== 1'b1) begin
         errors++; $display("FAIL thresh_saturate got af=%b ae=%b want 1 1", af0, ae0);
      end
      umb_af0 = 3'd1; umb_ae0 = 3'd1;
   endtask

   task automatic test_back_to_back;
      cycle0(1'b1, 6'h01, 1'b0, 1'b0);
      cycle0(1'b1, 6'h02, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle0(1'b1, 6'(6'h20 + i), 1'b1, 1'b0);
      checks++;
      if (dc0 !== 3'd2) begin
         errors++; $display("FAIL b2b_count got %0d want 2", dc0);
      end
      cycle0(1'b0, 6'h00, 1'b1, 1'b0);
      cycle0(1'b0, 6'h00, 1'b1, 1'b0);
   endtask

   task automatic test_errors;
      cycle0(1'b0, 6'h00, 1'b1, 1'b0);
      cycle0(1'b0, 6'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle0(1'b1, 6'(6'h30 + i), 1'b0, 1'b0);
      cycle0(1'b1, 6'h3F, 1'b0, 1'b0);
      cycle0(1'b1, 6'h3E, 1'b0, 1'b1);
      cycle0(1'b0, 6'h00, 1'b0, 1'b1);
      cycle0(1'b1, 6'h3D, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle0(1'b0, 6'h00, 1'b1, 1'b0);
      cycle0(1'b1, 6'h0A, 1'b1, 1'b0);
      cycle0(1'b0, 6'h00, 1'b1, 1'b1);
      checks++;
      if (ovf0 !== 1'b0 || unf0 !== 1'b0 || dc0 !== 3'd0) begin
         errors++; $display("FAIL err_final got ovf=%b unf=%b cnt=%0d want 0 0 0", ovf0, unf0, dc0);
      end
   endtask

   task automatic test_fwft;
      logic [5:0] exp;
      b1.write = 1'b1; b1.wr_data = 6'h2A;
      @(posedge clk); #1;
      b1.write = 1'b0;
      checks++;
      if (b1.rd_valid !== 1'b1 || b1.rd_data !== 6'h2A || dc1 !== 3'd1) begin
         errors++; $display("FAIL fwft_first got v=%b d=%h cnt=%0d want 1 2a 1", b1.rd_valid, b1.rd_data, dc1);
      end
      b1.read = 1'b1;
      @(posedge clk); #1;
      b1.read = 1'b0;
      checks++;
      if (b1.rd_valid !== 1'b0) begin
         errors++; $display("FAIL fwft_pop got v=%b want 0", b1.rd_valid);
      end
      for (int i = 0; i < 3; i++) begin
         b1.write = 1'b1; b1.wr_data = 6'(6'h05 * (i + 1)); sb1.push_back(b1.wr_data);
         @(posedge clk); #1;
      end
      b1.write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (sb1.size() == 0) begin
            errors++; $display("FAIL fwft_model_empty at step %0d", i);
         end else begin
            exp = sb1[0];
            if (b1.rd_valid !== 1'b1 || b1.rd_data !== exp) begin
               errors++; $display("FAIL fwft_head got v=%b d=%h want 1 %h", b1.rd_valid, b1.rd_data, exp);
            end
         end
         b1.read = 1'b1;
         b1.write = (i < 3);
         b1.wr_data = 6'(6'h21 + i);
         if (i < 3) sb1.push_back(b1.wr_data);
         @(posedge clk); #1;
         void'(sb1.pop_front());
      end
      b1.read = 1'b0; b1.write = 1'b0;
      checks++;
      if (b1.rd_valid !== 1'b0 || dc1 !== 3'd0) begin
         errors++; $display("FAIL fwft_drained got v=%b cnt=%0d want 0 0", b1.rd_valid, dc1);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) cycle0(1'b1, 6'(6'h2C + i), 1'b0, 1'b0);
      cycle0(1'b1, 6'h1B, 1'b1, 1'b0);
      b1.write = 1'b1; b1.wr_data = 6'h17;
      @(posedge clk); #1;
      b1.write = 1'b0;
      #2 reset_L = 1'b1;
      #1;
      checks++;
      if (dc0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || ae0 !== 1'b1 || af0 !== 1'b0 ||
          b0.rd_valid !== 1'b0 || b0.rd_data !== 6'd0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid0 got cnt=%0d e=%b f=%b ae=%b af=%b v=%b d=%h o=%b u=%b want 0 1 0 1 0 0 00 0 0",
                  dc0, empty0, full0, ae0, af0, b0.rd_valid, b0.rd_data, ovf0, unf0);
      end
      checks++;
      if (dc1 !== 3'd0 || b1.rd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid1 got cnt=%0d v=%b want 0 0", dc1, b1.rd_valid);
      end
      @(negedge clk);
      reset_L = 1'b0;
      sb0.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      cycle0(1'b1, 6'h05, 1'b0, 1'b0);
      cycle0(1'b0, 6'h00, 1'b1, 1'b0);
   endtask

   initial begin
      b0.write = 1'b0; b0.wr_data = '0; b0.read = 1'b0;
      b1.write = 1'b0; b1.wr_data = '0; b1.read = 1'b0;
      clr0 = 1'b0; clr1 = 1'b0;
      umb_af0 = 3'd1; umb_ae0 = 3'd1; umb_af1 = 3'd1; umb_ae1 = 3'd1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset_L = 1'b0;
      @(posedge clk); #1;
      test_fill_drain();
      test_thresholds();
      test_back_to_back();
      test_errors();
      test_fwft();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "bench timeout");
   end

endmodule
